// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bundle between the multi-cycle MIPS datapath and its main FSM
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_write;
  logic       branch;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       zero_ext;
  logic [1:0] pc_src;
  logic [1:0] alu_op;
  logic       illegal;
  logic [3:0] state;

  // Controller side: consumes opcode/zero, drives every control line
  modport master (
    input  opcode, zero,
    output pc_write, branch, pc_en, i_or_d, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, zero_ext, pc_src,
           alu_op, illegal, state
  );

  // Datapath side: supplies opcode/zero, obeys the control lines
  modport slave (
    output opcode, zero,
    input  pc_write, branch, pc_en, i_or_d, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, zero_ext, pc_src,
           alu_op, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multi-cycle MIPS datapath
module multicycle_control (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e     state_q, state_d;

  logic       pc_write, branch, i_or_d, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, zero_ext, illegal;
  logic [1:0] alu_src_b, pc_src, alu_op;

  // State register; reset forces FETCH immediately, so no writeback can follow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state and Moore decode; IMMEX/DECODE also look at the opcode
  always_comb begin
    state_d    = FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    zero_ext   = 1'b0;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = DECODE;
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is classified
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_RTYP:          state_d = RTYPEEX;
          OP_BEQ:           state_d = BEQEX;
          OP_ADDI, OP_ANDI: state_d = IMMEX;
          OP_J:             state_d = JEX;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        i_or_d  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        state_d   = FETCH;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = RTYPEWB;
      end
      RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // andi is a logical op, so its immediate is zero-extended
        if (bus.opcode == OP_ANDI) begin
          alu_op   = 2'b11;
          zero_ext = 1'b1;
        end
        state_d = IMMWB;
      end
      IMMWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.pc_write   = pc_write;
  assign bus.branch     = branch;
  assign bus.pc_en      = pc_write | (branch & bus.zero);
  assign bus.i_or_d     = i_or_d;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.zero_ext   = zero_ext;
  assign bus.pc_src     = pc_src;
  assign bus.alu_op     = alu_op;
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;

endmodule
